// File: rtl/div_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter_pkg
// Description : Shared types and constants for the divider arbiter: FSM state
//               encoding, response error codes and Q2.14 saturation values.
// Revision    : 1.0 - initial release
// ============================================================================
package div_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ZERO    = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    localparam logic [1:0] c_ERR_OK      = 2'b00;
    localparam logic [1:0] c_ERR_DIV0    = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    localparam logic [15:0] Q14_POS_MAX = 16'h7FFF;
    localparam logic [15:0] Q14_NEG_MAX = 16'h8001;

    // Divide-by-zero saturates toward the sign of the numerator; zero counts as positive.
    function automatic logic [15:0] zero_div_sat(input logic [15:0] num);
        return num[15] ? Q14_NEG_MAX : Q14_POS_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after rr_ptr, wrapping from NREQ-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   grant_id,
    output logic            valid
);

    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        grant_id = '0;
        valid    = 1'b0;
        w_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = IW'((int'(rr_ptr) + i) % NREQ);
            if (req[w_idx]) begin
                grant_id = w_idx;
                valid    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin arbiter sharing one Q2.14 divider among NREQ
//               requesters, with divide-by-zero short-circuit and a wait
//               timeout on the divider handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][15:0] req_num,
    input  logic [NREQ-1:0][15:0] req_den,
    output logic [NREQ-1:0]       ack,
    output logic [15:0]           resp_result,
    output logic [1:0]            resp_err,
    output logic                  div_start,
    output logic [15:0]           div_num,
    output logic [15:0]           div_den,
    input  logic                  div_done,
    input  logic [15:0]           div_result,
    output logic                  busy
);

    import div_arbiter_pkg::*;

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0]   c_TMAX    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   c_LAST    = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ACK_ONE = NREQ'(1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [TW-1:0]   r_tcnt;
    logic [IW-1:0]   r_id;
    logic [15:0]     r_num;
    logic [15:0]     r_den;
    logic [NREQ-1:0] r_ack;
    logic            r_div_start;
    logic [15:0]     r_resp_result;
    logic [1:0]      r_resp_err;

    logic [NREQ-1:0] w_req_eff;
    logic [IW-1:0]   w_grant_id;
    logic            w_grant_valid;
    logic [IW-1:0]   w_next_ptr;

    // r_ack is only nonzero in RELEASE; masking it keeps the requester just
    // acked from being regranted before it has had a chance to drop req.
    assign w_req_eff  = req & ~r_ack;
    assign w_next_ptr = (w_grant_id == c_LAST) ? '0 : w_grant_id + IW'(1);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req      (w_req_eff),
        .rr_ptr   (r_rr_ptr),
        .grant_id (w_grant_id),
        .valid    (w_grant_valid)
    );

    // Arbitration FSM. RELEASE may grant directly so the divider sees exactly
    // one idle cycle between back-to-back operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_tcnt        <= '0;
            r_id          <= '0;
            r_num         <= '0;
            r_den         <= '0;
            r_ack         <= '0;
            r_div_start   <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= c_ERR_OK;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE, ST_RELEASE: begin
                    r_div_start <= 1'b0;
                    if (w_grant_valid) begin
                        r_id     <= w_grant_id;
                        r_num    <= req_num[w_grant_id];
                        r_den    <= req_den[w_grant_id];
                        r_rr_ptr <= w_next_ptr;
                        if (req_den[w_grant_id] == 16'h0000) begin
                            r_state <= ST_ZERO;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_div_start <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_tcnt  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (div_done) begin
                        r_resp_result <= div_result;
                        r_resp_err    <= c_ERR_OK;
                        r_div_start   <= 1'b0;
                        r_ack         <= c_ACK_ONE << r_id;
                        r_state       <= ST_RELEASE;
                    end else if (r_tcnt == c_TMAX) begin
                        r_resp_result <= 16'h0000;
                        r_resp_err    <= c_ERR_TIMEOUT;
                        r_div_start   <= 1'b0;
                        r_ack         <= c_ACK_ONE << r_id;
                        r_state       <= ST_RELEASE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_ZERO: begin
                    r_resp_result <= zero_div_sat(r_num);
                    r_resp_err    <= c_ERR_DIV0;
                    r_ack         <= c_ACK_ONE << r_id;
                    r_state       <= ST_RELEASE;
                end
                default: begin
                    r_div_start <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;
    assign div_start   = r_div_start;
    assign div_num     = r_num;
    assign div_den     = r_den;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
